// File: rtl/alu_mdu_seq.sv
// =====================================================================
// alu_mdu_seq : registered EX-stage ALU with iterative RV32M mul/div
// rev 1.0
// =====================================================================
`default_nettype none

module alu_mdu_seq #(
  parameter int N      = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         sf,
  output logic         cf,
  output logic         vf,
  output logic         busy
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0]    c_IDLE  = 2'd0;
  localparam logic [1:0]    c_MUL   = 2'd1;
  localparam logic [1:0]    c_DIV   = 2'd2;
  localparam logic [CW-1:0] c_ITERS = CW'(N);
  localparam logic [N-1:0]  c_MIN   = {1'b1, {(N-1){1'b0}}};

  logic [1:0]     r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_opb;
  logic [1:0]     r_f3;
  logic           r_neg;
  logic           r_out_valid, r_zf, r_sf, r_cf, r_vf;
  logic [N-1:0]   r_result;

  logic           w_accept;
  logic [N-1:0]   w_bop, w_base;
  logic [N:0]     w_sum;
  logic           w_cf, w_sf, w_zf, w_vf;
  logic [SW-1:0]  w_sh;

  assign w_accept = in_valid & in_ready;
  assign w_bop    = op[2] ? -b : b;
  assign w_sum    = {1'b0, a} + {1'b0, w_bop};
  assign w_cf     = w_sum[N];
  assign w_sf     = w_sum[N-1];
  assign w_zf     = (w_sum[N-1:0] == '0);
  // Overflow judged against the true b so that subtracting the most negative value is handled
  assign w_vf     = op[2] ? ((a[N-1] != b[N-1]) && (w_sum[N-1] != a[N-1]))
                          : ((a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]));
  assign w_sh     = b[SW-1:0];

  always_comb begin
    w_base = '0;
    case (op[3:0])
      4'b0010: w_base = w_sum[N-1:0];
      4'b0110: w_base = w_sum[N-1:0];
      4'b0000: w_base = a & b;
      4'b0001: w_base = a | b;
      4'b0011: w_base = a ^ b;
      4'b1000: w_base = b;
      4'b1001: w_base = a << w_sh;
      4'b1010: w_base = a >> w_sh;
      4'b1011: w_base = $unsigned($signed(a) >>> w_sh);
      4'b1100: w_base = {{(N-1){1'b0}}, w_sf ^ w_vf};
      4'b1101: w_base = {{(N-1){1'b0}}, ~w_cf};
      default: w_base = '0;
    endcase
  end

  logic [2:0]   w_f3;
  logic         w_isdiv, w_sgn_a, w_sgn_b, w_na, w_nb, w_neg, w_special;
  logic [N-1:0] w_ma, w_mb, w_spec_res;

  assign w_f3    = op[2:0];
  assign w_isdiv = w_f3[2];
  assign w_sgn_a = w_isdiv ? ~w_f3[0] : ((w_f3 == 3'b001) || (w_f3 == 3'b010));
  assign w_sgn_b = w_isdiv ? ~w_f3[0] : (w_f3 == 3'b001);
  assign w_na    = w_sgn_a & a[N-1];
  assign w_nb    = w_sgn_b & b[N-1];
  assign w_ma    = w_na ? -a : a;
  assign w_mb    = w_nb ? -b : b;
  assign w_neg   = (w_isdiv && w_f3[1]) ? w_na : (w_na ^ w_nb);

  always_comb begin
    w_special  = 1'b0;
    w_spec_res = '0;
    if (w_isdiv) begin
      if (!DIV_EN) begin
        w_special = 1'b1;
      end else if (b == '0) begin
        w_special  = 1'b1;
        w_spec_res = w_f3[1] ? a : '1;
      end else if (!w_f3[0] && (a == c_MIN) && (b == '1)) begin
        w_special  = 1'b1;
        w_spec_res = w_f3[1] ? '0 : a;
      end
    end
  end

  // r_acc = {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  logic [N:0]     w_msum, w_rsh, w_rdiff;
  logic [2*N-1:0] w_iter, w_prod;
  logic [N-1:0]   w_dval, w_fin, w_mres;

  assign w_msum  = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_rsh   = r_acc[2*N-1:N-1];
  assign w_rdiff = w_rsh - {1'b0, r_opb};
  assign w_iter  = (r_state == c_MUL) ? {w_msum, r_acc[N-1:1]}
                 : (w_rdiff[N] ? {w_rsh[N-1:0], r_acc[N-2:0], 1'b0}
                               : {w_rdiff[N-1:0], r_acc[N-2:0], 1'b1});
  assign w_prod  = r_neg ? -r_acc : r_acc;
  assign w_dval  = r_f3[1] ? r_acc[2*N-1:N] : r_acc[N-1:0];
  assign w_fin   = (r_state == c_MUL) ? ((r_f3 == 2'b00) ? w_prod[N-1:0] : w_prod[2*N-1:N])
                                      : (r_neg ? -w_dval : w_dval);
  assign w_mres  = (r_state == c_IDLE) ? w_spec_res : w_fin;

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_accept && op[4] && !w_special) w_next = w_isdiv ? c_DIV : c_MUL;
      c_MUL,
      c_DIV:   if (r_cnt == c_ITERS) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
    if (flush) w_next = c_IDLE;
  end

  always_comb begin
    busy     = (r_state != c_IDLE);
    in_ready = (r_state == c_IDLE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      {r_zf, r_sf, r_cf, r_vf} <= 4'b0000;
      r_acc       <= '0;
      r_opb       <= '0;
      r_f3        <= 2'b00;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (flush) begin
        r_cnt <= '0;
      end else if (w_accept && !op[4]) begin
        r_out_valid <= 1'b1;
        r_result    <= w_base;
        {r_zf, r_sf, r_cf, r_vf} <= {w_zf, w_sf, w_cf, w_vf};
      end else if (w_accept && w_special) begin
        r_out_valid <= 1'b1;
        r_result    <= w_mres;
        {r_zf, r_sf, r_cf, r_vf} <= {(w_mres == '0), w_mres[N-1], 2'b00};
      end else if (w_accept) begin
        r_acc <= {{N{1'b0}}, (w_isdiv ? w_ma : w_mb)};
        r_opb <= w_isdiv ? w_mb : w_ma;
        r_f3  <= w_f3[1:0];
        r_neg <= w_neg;
        r_cnt <= '0;
      end else if (r_state != c_IDLE) begin
        if (r_cnt == c_ITERS) begin
          r_out_valid <= 1'b1;
          r_result    <= w_mres;
          {r_zf, r_sf, r_cf, r_vf} <= {(w_mres == '0), w_mres[N-1], 2'b00};
        end else begin
          r_acc <= w_iter;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zf;
  assign sf        = r_sf;
  assign cf        = r_cf;
  assign vf        = r_vf;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu_seq.sv
// =====================================================================
// tb_alu_mdu_seq : directed self-checking bench for alu_mdu_seq
// rev 1.0
// =====================================================================
`default_nettype none

module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [4:0]  op;
  logic [31:0] a, b, result;
  logic        out_valid, zero, sf, cf, vf, busy;

  int n_chk  = 0;
  int n_fail = 0;

  alu_mdu_seq #(.N(32), .DIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .result(result),
    .zero(zero), .sf(sf), .cf(cf), .vf(vf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // lat = clock edges after the accepting edge until out_valid is seen
  task automatic run(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp_r, input logic [3:0] exp_f, input int exp_lat);
    int lat, nbusy, nready;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; nbusy = 0; nready = 0;
    while (!out_valid && lat < 100) begin
      if (busy) nbusy++;
      if (in_ready) nready++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"},    lat,    exp_lat);
    check({tag, ".busyn"},  nbusy,  exp_lat);
    check({tag, ".ready"},  nready, 0);
    check({tag, ".res"},    result, exp_r);
    check({tag, ".flags"},  {zero, sf, cf, vf}, exp_f);
    check({tag, ".busy0"},  busy,   1'b0);
    @(posedge clk); #1;
    check({tag, ".pulse"},  out_valid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [4:0]  bb_op [4] = '{5'b00010, 5'b00110, 5'b00011, 5'b01000};
  logic [31:0] bb_a  [4] = '{32'd1, 32'd10, 32'hF0, 32'd0};
  logic [31:0] bb_b  [4] = '{32'd2, 32'd3, 32'hFF, 32'h55};
  logic [31:0] bb_r  [4] = '{32'd3, 32'd7, 32'h0F, 32'h55};

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ctl",   {out_valid, busy, in_ready}, 3'b000);
    check("rst.res",   result, 32'd0);
    check("rst.flags", {zero, sf, cf, vf}, 4'b0000);
    rst = 1'b0;
    #1;
    check("rst.ready", in_ready, 1'b1);

    // base ALU; flags ordered {zero, sf, cf, vf}
    run("sub_eq",  5'b00110, 32'd5,        32'd5,        32'd0,        4'b1010, 0);
    run("sub_ovf", 5'b00110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b0101, 0);
    run("add_cy",  5'b00010, 32'd1,        32'hFFFFFFFF, 32'd0,        4'b1010, 0);
    run("slt",     5'b01100, 32'hFFFFFFFF, 32'd1,        32'd1,        4'b0110, 0);
    run("sltu",    5'b01101, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b0110, 0);
    run("sra",     5'b01011, 32'h80000000, 32'd36,       32'hF8000000, 4'b0100, 0);
    run("srl",     5'b01010, 32'h80000000, 32'd36,       32'h08000000, 4'b0100, 0);

    // multiply
    run("mulh",    5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, 33);
    run("mulhu",   5'b10011, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, 33);
    run("mul",     5'b10000, 32'h80000000, 32'h80000000, 32'd0,        4'b1000, 33);
    run("mulhsu",  5'b10010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 4'b0100, 33);
    run("mulhu2",  5'b10011, 32'hFFFFFFFF, 32'd2,        32'd1,        4'b0000, 33);

    // divide
    run("div",     5'b10100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b0100, 33);
    run("rem",     5'b10110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b0100, 33);
    run("divu",    5'b10101, 32'd100,      32'd7,        32'd14,       4'b0000, 33);
    run("remu",    5'b10111, 32'd100,      32'd7,        32'd2,        4'b0000, 33);
    run("divu0",   5'b10101, 32'd9,        32'd0,        32'hFFFFFFFF, 4'b0100, 0);
    run("remu0",   5'b10111, 32'd9,        32'd0,        32'd9,        4'b0000, 0);
    run("divovf",  5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0100, 0);
    run("removf",  5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        4'b1000, 0);

    // back-to-back base ops with in_valid held
    for (int i = 0; i < 4; i++) begin
      op = bb_op[i]; a = bb_a[i]; b = bb_b[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("b2b%0d", i), {out_valid, result}, {1'b1, bb_r[i]});
    end
    in_valid = 1'b0;

    // flush a DIVU at iteration 10
    op = 5'b10101; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush.ctl", {out_valid, busy, in_ready}, 3'b001);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("flush.nov", n, 0);
    check("flush.res", result, 32'h55);

    // a transfer coinciding with flush is dropped
    op = 5'b00010; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flushx.ov",  out_valid, 1'b0);
    check("flushx.res", result, 32'h55);
    run("post_flush", 5'b00010, 32'd3, 32'd4, 32'd7, 4'b0000, 0);

    // reset in the middle of a MUL
    op = 5'b10000; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.ctl",   {out_valid, busy, in_ready}, 3'b000);
    check("midrst.res",   result, 32'd0);
    check("midrst.flags", {zero, sf, cf, vf}, 4'b0000);
    rst = 1'b0;
    #1;
    run("post_rst", 5'b10000, 32'd3, 32'd5, 32'd15, 4'b0000, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
